// File: rtl/siso_pkg.sv
// Shared types and helpers for the serializer feeding the SISO shift stage.
package siso_pkg;

   // Serializer control state: waiting for a word, or walking its bits out.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Bit-counter width for a given word length (never narrower than 1 bit).
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. Takes a word on a valid/ready load
// handshake and emits it one bit per enabled clock into the downstream SISO.
//
// Handshake: a word is captured on any rising edge where load && ready.
// ready is combinational: high in IDLE, or in SHIFT on the enabled cycle that
// consumes the last bit (so back-to-back words have no bubble), and always low
// while rst is asserted. Upstream holds par_inp and load until ready is seen.
module piso_serializer
   import siso_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic [WIDTH-1:0] par_inp,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             out_vld,
   output logic             done,
   output logic             state_dbg
);

   localparam int             CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   ser_state_t       state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ready_raw;
   logic             accept;

   // Control and datapath registers; reset aborts any word in flight at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, shift/count updates and registered-state-derived outputs.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      ready_raw = 1'b0;
      out       = IDLE_LEVEL;
      out_vld   = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;

      case (state)
         IDLE: begin
            ready_raw = 1'b1;
            accept    = load && rst;
            if (accept) begin
               shreg_nxt = par_inp;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            out     = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
            out_vld = 1'b1;
            if (enb) begin
               if (cnt == LAST) begin
                  // Last bit is being consumed: reload gaplessly or go idle.
                  done      = 1'b1;
                  ready_raw = 1'b1;
                  accept    = load && rst;
                  cnt_nxt   = '0;
                  if (accept) begin
                     shreg_nxt = par_inp;
                  end else begin
                     shreg_nxt = '0;
                     state_nxt = IDLE;
                  end
               end else begin
                  shreg_nxt = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]}
                                        : {shreg[WIDTH-2:0], 1'b0};
                  cnt_nxt   = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign ready     = ready_raw && rst;
   assign state_dbg = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one LSB-first and one MSB-first
// instance share stimulus and are compared every cycle against a queue model.
module tb_piso_serializer;

   localparam int W = 8;

   // ---------------- clock / reset / inputs ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enb = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] par_inp = '0;

   always #5 clk = ~clk;

   logic ready_a, out_a, vld_a, done_a, st_a;
   logic ready_b, out_b, vld_b, done_b, st_b;

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
      .clk(clk), .rst(rst), .enb(enb), .par_inp(par_inp), .load(load),
      .ready(ready_a), .out(out_a), .out_vld(vld_a), .done(done_a),
      .state_dbg(st_a)
   );

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
      .clk(clk), .rst(rst), .enb(enb), .par_inp(par_inp), .load(load),
      .ready(ready_b), .out(out_b), .out_vld(vld_b), .done(done_b),
      .state_dbg(st_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each queue holds the bits still to be shown on out, in emission order.
   bit qa[$];
   bit qb[$];
   bit last_acc = 1'b0;

   function automatic bit exp_ready();
      return rst && (qa.size() == 0 || (qa.size() == 1 && enb));
   endfunction

   always @(posedge clk or negedge rst) begin : model
      bit rdy;
      if (!rst) begin
         qa.delete();
         qb.delete();
         last_acc = 1'b0;
      end else begin
         rdy = exp_ready();
         if (enb && qa.size() > 0) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
         last_acc = load && rdy;
         if (last_acc) begin
            for (int i = 0; i < W; i++) begin
               qa.push_back(par_inp[i]);
               qb.push_back(par_inp[W-1-i]);
            end
         end
      end
   end

   // ---------------- compare + capture on the falling edge ----------------
   logic [31:0] cap_a, cap_b;
   int          n_vld_a, n_done_a, done_at_a, first_vld_a, last_vld_a, cyc;

   task automatic clear_caps();
      cap_a       = '0;
      cap_b       = '0;
      n_vld_a     = 0;
      n_done_a    = 0;
      done_at_a   = 0;
      first_vld_a = -1;
      last_vld_a  = -1;
   endtask

   initial begin
      cyc = 0;
      clear_caps();
   end

   always @(negedge clk) begin : scoreboard
      bit ev, eo_a, eo_b, ed;
      ev   = (qa.size() > 0);
      eo_a = ev ? qa[0] : 1'b0;
      eo_b = ev ? qb[0] : 1'b0;
      ed   = rst && (qa.size() == 1) && enb;
      chk("a_outputs", {28'd0, ready_a, vld_a, done_a, out_a}, {28'd0, exp_ready(), ev, ed, eo_a});
      chk("b_outputs", {28'd0, ready_b, vld_b, done_b, out_b}, {28'd0, exp_ready(), ev, ed, eo_b});
      cyc++;
      if (vld_a) begin
         n_vld_a++;
         if (first_vld_a < 0) first_vld_a = cyc;
         last_vld_a = cyc;
      end
      if (vld_a && enb) cap_a = {cap_a[30:0], out_a};
      if (vld_b && enb) cap_b = {cap_b[30:0], out_b};
      if (done_a) begin
         n_done_a++;
         done_at_a = n_vld_a;
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1. reset held with a pending load
      rst = 1'b0; load = 1'b1; par_inp = 8'hFF; enb = 1'b1;
      repeat (3) step();
      chk("rst_out", {31'd0, out_a}, 32'd0);
      chk("rst_vld", {31'd0, vld_a}, 32'd0);
      chk("rst_ready", {31'd0, ready_a}, 32'd0);
      chk("rst_done", {31'd0, done_a}, 32'd0);
      rst = 1'b1; load = 1'b0;
      step();
      chk("post_rst_ready", {31'd0, ready_a}, 32'd1);
      chk("post_rst_no_word", {31'd0, vld_a}, 32'd0);

      // 2/3. single word B4, LSB-first (a) and MSB-first (b)
      clear_caps();
      load = 1'b1; par_inp = 8'hB4;
      step();
      load = 1'b0;
      repeat (10) step();
      chk("lsb_b4_bits", cap_a, 32'h2D);
      chk("msb_b4_bits", cap_b, 32'hB4);
      chk("b4_vld_cycles", n_vld_a, 8);
      chk("b4_done_count", n_done_a, 1);
      chk("b4_done_at", done_at_a, 8);
      chk("b4_idle_after", {30'd0, vld_a, out_a}, 32'd0);

      // 4. enable stall of 3 cycles after the third bit
      clear_caps();
      load = 1'b1; par_inp = 8'hB4;
      step();
      load = 1'b0;
      repeat (2) step();
      enb = 1'b0;
      repeat (3) step();
      enb = 1'b1;
      repeat (8) step();
      chk("stall_bits", cap_a, 32'h2D);
      chk("stall_vld_cycles", n_vld_a, 11);
      chk("stall_done_count", n_done_a, 1);

      // 5. back-to-back A5 then 3C
      clear_caps();
      load = 1'b1; par_inp = 8'hA5;
      step();
      par_inp = 8'h3C;
      repeat (8) step();
      load = 1'b0;
      repeat (10) step();
      chk("b2b_lsb_bits", cap_a, 32'hA53C);
      chk("b2b_msb_bits", cap_b, 32'hA53C);
      chk("b2b_vld_cycles", n_vld_a, 16);
      chk("b2b_contiguous", last_vld_a - first_vld_a + 1, 16);
      chk("b2b_done_count", n_done_a, 2);
      chk("b2b_done_at", done_at_a, 16);

      // 6. asynchronous reset mid-word
      load = 1'b1; par_inp = 8'hFF;
      step();
      load = 1'b0;
      repeat (4) step();
      #2 rst = 1'b0;
      #1;
      chk("midrst_vld", {31'd0, vld_a}, 32'd0);
      chk("midrst_out", {31'd0, out_a}, 32'd0);
      chk("midrst_ready", {31'd0, ready_a}, 32'd0);
      chk("midrst_done", {31'd0, done_b}, 32'd0);
      step();
      rst = 1'b1;
      clear_caps();
      load = 1'b1; par_inp = 8'h01;
      step();
      load = 1'b0;
      repeat (10) step();
      chk("after_rst_lsb", cap_a, 32'h80);
      chk("after_rst_msb", cap_b, 32'h01);
      chk("after_rst_vld", n_vld_a, 8);

      // Randomized traffic with stalls, held loads and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         enb = ($urandom_range(0, 3) != 0);
         if (!load || last_acc) begin
            load    = ($urandom_range(0, 2) != 0);
            par_inp = W'($urandom);
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
         end
         step();
      end
      load = 1'b0; enb = 1'b1;
      repeat (12) step();
      chk("drain_idle", {31'd0, vld_a}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
